// File: rtl/backprop_layer_sequencer_if.sv
// Handshake bundle between the backprop layer sequencer and its surroundings
// (backprop stack, z_to_z_calculator, weight-gradient consumer).
interface backprop_layer_sequencer_if #(
   parameter int layer_bits = 2
);
   logic                  start;
   logic                  abort;
   logic                  cost_valid;
   logic                  z_ack;
   logic                  set_cost;
   logic                  set_diff_act;
   logic                  start_new_layer;
   logic                  stack_pop;
   logic [layer_bits-1:0] layer_idx;
   logic                  z_valid;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, abort, cost_valid, z_ack,
      output set_cost, set_diff_act, start_new_layer, stack_pop,
             layer_idx, z_valid, busy, done
   );

   modport slave (
      output start, abort, cost_valid, z_ack,
      input  set_cost, set_diff_act, start_new_layer, stack_pop,
             layer_idx, z_valid, busy, done
   );
endinterface

// File: rtl/backprop_layer_sequencer.sv
// Sequences the z_to_z_calculator through one backward pass, from the output
// layer down to layer 0, handing each diff_z_to_z to the consumer via valid/ack.
module backprop_layer_sequencer #(
   parameter int num_layer    = 3,
   parameter int layer_bits   = 2,
   parameter int calc_latency = 1,
   parameter int lat_bits     = 4
) (
   input logic                         clk,
   input logic                         rst_n,
   backprop_layer_sequencer_if.master  bus
);

   localparam logic [layer_bits-1:0] LAST_LAYER = layer_bits'(num_layer - 1);
   localparam logic [lat_bits-1:0]   LAT_LAST   = lat_bits'(calc_latency - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_COST,
      LOAD_COST,
      LOAD_ACT,
      COMPUTE,
      WAIT_ACK,
      DONE
   } state_t;

   state_t                state, state_nxt;
   logic [lat_bits-1:0]   lat_cnt;
   logic [layer_bits-1:0] layer_idx_q;

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         lat_cnt     <= '0;
         layer_idx_q <= '0;
      end else begin
         state <= state_nxt;
         if (bus.abort) begin
            lat_cnt     <= '0;
            layer_idx_q <= '0;
         end else begin
            case (state)
               LOAD_COST: layer_idx_q <= LAST_LAYER;
               LOAD_ACT:  lat_cnt     <= '0;
               COMPUTE:   lat_cnt     <= lat_cnt + 1'b1;
               WAIT_ACK: begin
                  // Decrement only when nonzero: layer 0 leaves through DONE.
                  if (bus.z_ack && (layer_idx_q != '0))
                     layer_idx_q <= layer_idx_q - 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      state_nxt = state;
      if (bus.abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:      if (bus.start)      state_nxt = WAIT_COST;
            WAIT_COST: if (bus.cost_valid) state_nxt = LOAD_COST;
            LOAD_COST: state_nxt = LOAD_ACT;
            LOAD_ACT:  state_nxt = COMPUTE;
            COMPUTE:   if (lat_cnt == LAT_LAST) state_nxt = WAIT_ACK;
            WAIT_ACK: begin
               if (bus.z_ack)
                  state_nxt = (layer_idx_q == '0) ? DONE : LOAD_ACT;
            end
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   // Moore outputs only: nothing here depends on an input.
   always_comb begin
      bus.set_cost        = 1'b0;
      bus.set_diff_act    = 1'b0;
      bus.start_new_layer = 1'b0;
      bus.stack_pop       = 1'b0;
      bus.z_valid         = 1'b0;
      bus.done            = 1'b0;
      bus.busy            = (state != IDLE);
      case (state)
         LOAD_COST: bus.set_cost = 1'b1;
         LOAD_ACT: begin
            bus.set_diff_act    = 1'b1;
            bus.stack_pop       = 1'b1;
            // The output layer starts from diff_cost; deeper layers chain.
            bus.start_new_layer = (layer_idx_q != LAST_LAYER);
         end
         WAIT_ACK:  bus.z_valid = 1'b1;
         DONE:      bus.done    = 1'b1;
         default: ;
      endcase
   end

   assign bus.layer_idx = layer_idx_q;

endmodule

// File: doc/backprop_layer_sequencer.md
Name: backprop_layer_sequencer

Overview:
- Controller FSM that sequences the z_to_z_calculator through one backward pass, from the output layer down to layer 0.
- Per layer it drives set_cost, set_diff_act and start_new_layer, and pops diff_act/diff_dense from the backprop stack.
- It waits a fixed compute latency, then hands diff_z_to_z to the weight-gradient consumer via valid/ack.
- Sits between the backprop stack, the z_to_z_calculator and the gradient/update stage.

Parameters:
- num_layer, 3, number of layers in one backward pass (>=1).
- layer_bits, 2, width of layer_idx; must satisfy 2**layer_bits >= num_layer.
- calc_latency, 1, cycles z_to_z_calculator needs after a load before diff_z_to_z is valid (>=1).
- lat_bits, 4, width of the latency counter; 2**lat_bits > calc_latency.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a backward pass; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE, no done pulse.
- cost_valid  input  1  diff_cost from the forward pass is valid on the calculator input.
- z_ack  input  1  consumer accepted current diff_z_to_z.
- set_cost  output  1  one-cycle load strobe for diff_cost.
- set_diff_act  output  1  one-cycle load strobe for diff_act/diff_dense.
- start_new_layer  output  1  one-cycle strobe; calculator chains its previous diff_z_to_z instead of diff_cost.
- stack_pop  output  1  one-cycle pop of backprop stack, same cycle as set_diff_act.
- layer_idx  output  layer_bits  layer currently processed.
- z_valid  output  1  diff_z_to_z valid for consumer.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of pass.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, lat counter=0, layer_idx=0. All strobes, z_valid, busy and done are 0.
- All outputs are Moore-decoded from registered state; no input-to-output combinational path.
- States and transitions:
  - IDLE: start=1 -> WAIT_COST.
  - WAIT_COST: cost_valid=1 -> LOAD_COST; otherwise stay.
  - LOAD_COST: set_cost=1; layer_idx loaded with num_layer-1 -> LOAD_ACT.
  - LOAD_ACT: set_diff_act=1 and stack_pop=1. start_new_layer=1 only if layer_idx != num_layer-1. Lat counter cleared -> COMPUTE.
  - COMPUTE: counter increments each cycle; after exactly calc_latency cycles -> WAIT_ACK.
  - WAIT_ACK: z_valid=1, held until z_ack=1. Then: layer_idx==0 -> DONE; otherwise layer_idx decrements -> LOAD_ACT.
  - DONE: done=1 for one cycle -> IDLE.
- Latency: start sampled at edge t puts WAIT_COST in cycle t+1. With cost_valid high in t+1:
  - set_cost in t+2, set_diff_act in t+3.
  - z_valid first high in t+4+calc_latency.
- Per-layer cost with immediate ack: 2+calc_latency cycles.
- Exactly num_layer stack_pops and one set_cost per completed pass.
- Boundary conditions:
  - start while busy: ignored.
  - cost_valid in IDLE: ignored.
  - z_ack outside WAIT_ACK: ignored.
  - z_ack already high on entry to WAIT_ACK: accepted in that cycle, so z_valid is high for exactly 1 cycle.
  - abort: highest priority after reset. Next state is IDLE from any state, counters cleared, no done pulse. Abort in the same cycle as stack_pop still lets that pop occur (the output is already asserted).
  - num_layer=1: start_new_layer is never asserted; DONE follows the first ack.
  - rst_n low mid-pass: same as reset above, regardless of state.
  - layer_idx never wraps below 0; it is only decremented when nonzero.
  - start and abort in the same IDLE cycle: stays IDLE.

Test Plan:
- Reset, then num_layer=3, calc_latency=2. start at cycle 0, cost_valid high, z_ack tied high:
  - set_cost @2.
  - set_diff_act/stack_pop @3, 7, 11.
  - start_new_layer @7 and 11 only.
  - layer_idx 2, 1, 0.
  - z_valid @6, 10, 14.
  - done @15; busy low @16.
- cost_valid held low 5 cycles after start -> machine stays in WAIT_COST, no strobes. cost_valid rises -> set_cost the next cycle.
- z_ack withheld 4 cycles in layer 1 -> z_valid held, layer_idx=1 stable, no extra stack_pop. Pass completes after ack.
- abort asserted in COMPUTE of layer 1 -> IDLE next cycle, busy=0, done never pulses. A new start then runs a full pass from layer 2.
- start pulsed during busy, plus z_ack pulsed in COMPUTE -> no effect: exactly 3 pops, 1 done.
- rst_n low for 1 cycle in WAIT_ACK -> all outputs 0 next cycle. num_layer=1 variant -> single pop, no start_new_layer, done after first ack.
